// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the board-level reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT    = 2'b00,
    WAIT_LOCK = 2'b01,
    RELEASE   = 2'b10,
    RUN       = 2'b11
  } seq_state_t;

  typedef enum logic [1:0] {
    POR  = 2'b01,
    LOCK = 2'b10,
    SW   = 2'b11
  } rst_cause_t;

  localparam int RESTART_W = 8;

  function automatic logic [RESTART_W-1:0] sat_inc(input logic [RESTART_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reset_seq_ctrl_if.sv
// Sequencer control/status bundle: lock and software request in, domain resets and status out.
interface reset_seq_ctrl_if #(
  parameter int NUM_DOM = 4
);
  import reset_seq_pkg::*;

  logic                 pll_lock_i;
  logic                 sw_rst_req_i;
  logic [NUM_DOM-1:0]   dom_rst_n_o;
  logic                 seq_busy_o;
  logic                 seq_done_o;
  seq_state_t           state_o;
  rst_cause_t           rst_cause_o;
  logic [RESTART_W-1:0] restart_cnt_o;

  modport master (
    output pll_lock_i, sw_rst_req_i,
    input  dom_rst_n_o, seq_busy_o, seq_done_o, state_o, rst_cause_o, restart_cnt_o
  );

  modport slave (
    input  pll_lock_i, sw_rst_req_i,
    output dom_rst_n_o, seq_busy_o, seq_done_o, state_o, rst_cause_o, restart_cnt_o
  );

endinterface

// File: rtl/reset_seq_ctrl_lock_sync.sv
// Two-flop level synchronizer for the asynchronous PLL lock input.
module lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta   <= 1'b0;
      sync_o <= 1'b0;
    end else begin
      meta   <= async_i;
      sync_o <= meta;
    end
  end

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, qualifies PLL lock, then releases
// domains one at a time; restarts on lock loss or software request.
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOM   = 4,
  parameter int HOLD_CYC  = 16,
  parameter int LOCK_FILT = 4,
  parameter int STEP_CYC  = 8,
  parameter int CNT_W     = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  reset_seq_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DOM);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  seq_state_t           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_DOM-1:0]   dom_q, dom_d;
  rst_cause_t           cause_q, cause_d;
  logic [RESTART_W-1:0] restart_q, restart_d;
  logic                 busy_q, done_q;
  logic                 lock_s;
  logic                 restart_ev;
  rst_cause_t           restart_cause;

  lock_sync u_lock_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(bus.pll_lock_i),
    .sync_o (lock_s)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    dom_d         = dom_q;
    cause_d       = cause_q;
    restart_d     = restart_q;
    restart_ev    = 1'b0;
    restart_cause = SW;

    unique case (state_q)
      ASSERT: begin
        dom_d = '0;
        // A software request here only re-arms the hold; it is not counted as a restart.
        if (bus.sw_rst_req_i) begin
          cnt_d   = '0;
          cause_d = SW;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (bus.sw_rst_req_i) begin
          restart_ev = 1'b1;
        end else if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          restart_ev    = 1'b1;
          restart_cause = LOCK;
        end else if (bus.sw_rst_req_i) begin
          restart_ev = 1'b1;
        end else if (cnt_q == STEP_LAST) begin
          dom_d[idx_q] = 1'b1;
          cnt_d        = '0;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        dom_d = '1;
        if (!lock_s) begin
          restart_ev    = 1'b1;
          restart_cause = LOCK;
        end else if (bus.sw_rst_req_i) begin
          restart_ev = 1'b1;
        end
      end
      default: state_d = ASSERT;
    endcase

    // Every restart drops all domains together on the same edge as the state change.
    if (restart_ev) begin
      state_d   = ASSERT;
      cnt_d     = '0;
      idx_d     = '0;
      dom_d     = '0;
      cause_d   = restart_cause;
      restart_d = sat_inc(restart_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      dom_q     <= '0;
      cause_q   <= POR;
      restart_q <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dom_q     <= dom_d;
      cause_q   <= cause_d;
      restart_q <= restart_d;
      busy_q    <= (state_d != RUN);
      done_q    <= (state_d == RUN);
    end
  end

  assign bus.dom_rst_n_o   = dom_q;
  assign bus.seq_busy_o    = busy_q;
  assign bus.seq_done_o    = done_q;
  assign bus.state_o       = state_q;
  assign bus.rst_cause_o   = cause_q;
  assign bus.restart_cnt_o = restart_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl; edge numbers count from the first edge with rst_i=0.
module tb_reset_seq_ctrl;
  import reset_seq_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  int   base_e;

  always #5 clk_i = ~clk_i;

  reset_seq_ctrl_if #(.NUM_DOM(4)) bus ();

  reset_seq_ctrl #(
    .NUM_DOM  (4),
    .HOLD_CYC (16),
    .LOCK_FILT(4),
    .STEP_CYC (8),
    .CNT_W    (8)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk_i);
    edge_n++;
    #1;
  endtask

  task automatic tickTo(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic applyStimulus(input logic lock, input logic sw);
    bus.pll_lock_i   = lock;
    bus.sw_rst_req_i = sw;
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    edge_n = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic checkDom(input string tag, input logic [3:0] dom);
    checkOutput({tag, ".dom"}, 32'(bus.dom_rst_n_o), 32'(dom));
  endtask

  task automatic checkState(input string tag, input seq_state_t st);
    checkOutput({tag, ".state"}, 32'(bus.state_o), 32'(st));
  endtask

  task automatic checkAll(input string tag, input logic [3:0] dom, input seq_state_t st,
                          input logic busy, input logic done, input rst_cause_t cause,
                          input logic [7:0] cnt);
    checkDom(tag, dom);
    checkState(tag, st);
    checkOutput({tag, ".busy"},  32'(bus.seq_busy_o),    32'(busy));
    checkOutput({tag, ".done"},  32'(bus.seq_done_o),    32'(done));
    checkOutput({tag, ".cause"}, 32'(bus.rst_cause_o),   32'(cause));
    checkOutput({tag, ".rcnt"},  32'(bus.restart_cnt_o), 32'(cnt));
  endtask

  initial begin
    // Lock held low until edge 40: release waits for sync + filter + one step.
    applyStimulus(1'b0, 1'b0);
    doReset();
    checkAll("lowlock_por", 4'b0000, ASSERT, 1'b1, 1'b0, POR, 8'd0);
    tickTo(16); checkState("lowlock_e16", WAIT_LOCK);
    tickTo(40); applyStimulus(1'b1, 1'b0);
    tickTo(45); checkState("lowlock_e45", WAIT_LOCK); checkDom("lowlock_e45", 4'b0000);
    tickTo(46); checkState("lowlock_e46", RELEASE);
    tickTo(53); checkDom("lowlock_e53", 4'b0000);
    tickTo(54); checkDom("lowlock_e54", 4'b0001);

    // One-cycle lock glitch inside WAIT_LOCK restarts the filter count.
    applyStimulus(1'b1, 1'b0);
    doReset();
    tickTo(17); applyStimulus(1'b0, 1'b0);
    tickTo(18); applyStimulus(1'b1, 1'b0);
    tickTo(22); checkState("glitch_e22", WAIT_LOCK); checkDom("glitch_e22", 4'b0000);
    tickTo(23); checkState("glitch_e23", WAIT_LOCK);
    tickTo(24); checkState("glitch_e24", RELEASE);
    tickTo(28); checkDom("glitch_e28", 4'b0000);
    tickTo(31); checkDom("glitch_e31", 4'b0000);
    tickTo(32); checkDom("glitch_e32", 4'b0001);

    // Nominal power-on sequence with lock stable.
    applyStimulus(1'b1, 1'b0);
    doReset();
    checkAll("nom_por", 4'b0000, ASSERT, 1'b1, 1'b0, POR, 8'd0);
    tickTo(27); checkDom("nom_e27", 4'b0000);
    tickTo(28); checkDom("nom_e28", 4'b0001);
    tickTo(35); checkDom("nom_e35", 4'b0001);
    tickTo(36); checkDom("nom_e36", 4'b0011);
    tickTo(44); checkDom("nom_e44", 4'b0111);
    tickTo(51); checkAll("nom_e51", 4'b0111, RELEASE, 1'b1, 1'b0, POR, 8'd0);
    tickTo(52); checkAll("nom_e52", 4'b1111, RUN, 1'b0, 1'b1, POR, 8'd0);

    // Lock loss in RUN drops every domain on one edge, then the sequence replays.
    tickTo(60); applyStimulus(1'b0, 1'b0);
    tickTo(62); checkDom("lloss_e62", 4'b1111); checkState("lloss_e62", RUN);
    tickTo(63); checkAll("lloss_e63", 4'b0000, ASSERT, 1'b1, 1'b0, LOCK, 8'd1);
    applyStimulus(1'b1, 1'b0);
    tickTo(78); checkState("replay_e78", ASSERT);
    tickTo(79); checkState("replay_e79", WAIT_LOCK);
    tickTo(83); checkState("replay_e83", RELEASE);
    tickTo(90); checkDom("replay_e90", 4'b0000);
    tickTo(91); checkDom("replay_e91", 4'b0001);

    // Software restart in RELEASE, then a second request that re-arms the hold.
    tickTo(93); applyStimulus(1'b1, 1'b1);
    tickTo(94); applyStimulus(1'b1, 1'b0);
    checkAll("sw_e94", 4'b0000, ASSERT, 1'b1, 1'b0, SW, 8'd2);
    tickTo(98); applyStimulus(1'b1, 1'b1);
    tickTo(99); applyStimulus(1'b1, 1'b0);
    checkAll("sw2_e99", 4'b0000, ASSERT, 1'b1, 1'b0, SW, 8'd2);
    tickTo(110); checkState("sw2_e110", ASSERT);
    tickTo(114); checkState("sw2_e114", ASSERT);
    tickTo(115); checkState("sw2_e115", WAIT_LOCK);
    tickTo(127); checkDom("sw2_e127", 4'b0001);
    tickTo(151); checkAll("sw2_e151", 4'b1111, RUN, 1'b0, 1'b1, SW, 8'd2);

    // Lock loss and software request seen on the same edge: lock wins, one increment.
    tickTo(155); applyStimulus(1'b0, 1'b0);
    tickTo(157); checkState("both_e157", RUN); applyStimulus(1'b0, 1'b1);
    tickTo(158); applyStimulus(1'b1, 1'b0);
    checkAll("both_e158", 4'b0000, ASSERT, 1'b1, 1'b0, LOCK, 8'd3);

    // Repeated software restarts from WAIT_LOCK drive the counter into saturation.
    for (int i = 1; i <= 256; i++) begin
      tickTo(edge_n + 16);
      if (i == 1) checkState("sat_first_wait", WAIT_LOCK);
      applyStimulus(1'b1, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0);
      if (i == 1)   checkOutput("sat_i1",   32'(bus.restart_cnt_o), 32'd4);
      if (i == 251) checkOutput("sat_i251", 32'(bus.restart_cnt_o), 32'd254);
      if (i == 252) checkOutput("sat_i252", 32'(bus.restart_cnt_o), 32'd255);
    end
    checkAll("sat_end", 4'b0000, ASSERT, 1'b1, 1'b0, SW, 8'd255);

    // Synchronous reset mid-release returns every output to its reset value.
    base_e = edge_n;
    tickTo(base_e + 30);
    checkAll("mid_pre", 4'b0001, RELEASE, 1'b1, 1'b0, SW, 8'd255);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkAll("mid_rst", 4'b0000, ASSERT, 1'b1, 1'b0, POR, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
